// File: rtl/pd_sequence_arbiter_if.sv
// Request/command bundle between the PMU-side sources and the power-domain
// sequence arbiter. The master side drives requests and APC completions; the
// slave side (the arbiter) returns power commands, confirmed state and status.
interface pd_sequence_arbiter_if #(
  parameter int unsigned NUM_DOM = 4
);

  localparam int unsigned GW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  logic               en;       // arbitration enable, blocks new grants only
  logic [NUM_DOM-1:0] req;      // requested power state per domain (1 = on)
  logic [NUM_DOM-1:0] done;     // APC completion per domain
  logic               err_clr;  // clears all sticky error flags
  logic [NUM_DOM-1:0] pwr;      // power command to the APC wrappers
  logic [NUM_DOM-1:0] stat;     // confirmed power state per domain
  logic               busy;     // a transition or settling gap is in progress
  logic [GW-1:0]      grant;    // domain in transition (valid while in TRANS)
  logic [NUM_DOM-1:0] err;      // sticky per-domain timeout flags

  modport master (
    output en, req, done, err_clr,
    input  pwr, stat, busy, grant, err
  );

  modport slave (
    input  en, req, done, err_clr,
    output pwr, stat, busy, grant, err
  );

endinterface

// File: rtl/pd_sequence_arbiter.sv
// Power-domain sequence arbiter. Serialises power-up/power-down requests so at
// most one domain is in transition at a time, which bounds inrush current.
// Power-downs take priority over power-ups; within a class the winner is picked
// round-robin. Each transition has a timeout that reverts the command and sets a
// sticky error flag, and every transition is followed by a settling gap.
module pd_sequence_arbiter #(
  parameter int unsigned        NUM_DOM = 4,
  parameter int unsigned        GAP_CYC = 8,
  parameter int unsigned        TIMEOUT = 1024,
  parameter logic [NUM_DOM-1:0] RST_PWR = {NUM_DOM{1'b1}}
) (
  input logic                   clk_i,
  input logic                   rst_i,
  pd_sequence_arbiter_if.slave  bus
);

  localparam int unsigned GW   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StTrans,
    StGap
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_DOM-1:0] pwr_q, pwr_d;
  logic [NUM_DOM-1:0] stat_q, stat_d;
  logic [NUM_DOM-1:0] err_q, err_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      rr_q, rr_d;
  logic [TmrW-1:0]    timer_q, timer_d;
  logic [GapW-1:0]    gap_q, gap_d;

  logic [NUM_DOM-1:0] pend;
  logic [NUM_DOM-1:0] dn_pend;
  logic [NUM_DOM-1:0] up_pend;
  logic [NUM_DOM-1:0] cand;
  logic [GW-1:0]      scan_idx;
  logic [GW-1:0]      win;
  logic               win_vld;

  // Classify pending domains and pick the round-robin winner of the active class.
  always_comb begin
    pend     = bus.req ^ stat_q;
    dn_pend  = pend & stat_q;
    up_pend  = pend & ~stat_q;
    // Power-downs first: they never add inrush, and they free budget for the ups.
    cand     = (|dn_pend) ? dn_pend : up_pend;
    win      = '0;
    win_vld  = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      scan_idx = GW'((32'(rr_q) + i) % NUM_DOM);
      if (!win_vld && cand[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state and datapath updates for the IDLE/TRANS/GAP sequencer.
  always_comb begin
    state_d = state_q;
    pwr_d   = pwr_q;
    stat_d  = stat_q;
    err_d   = bus.err_clr ? '0 : err_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    gap_d   = gap_q;

    unique case (state_q)
      StIdle: begin
        if (bus.en && win_vld) begin
          pwr_d[win] = ~stat_q[win];
          grant_d    = win;
          timer_d    = '0;
          rr_d       = GW'((32'(win) + 1) % NUM_DOM);
          state_d    = StTrans;
        end
      end

      StTrans: begin
        // Done wins over a coincident timeout.
        if (bus.done[grant_q]) begin
          stat_d[grant_q] = pwr_q[grant_q];
          if (GAP_CYC == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            gap_d   = GapW'(GAP_CYC - 1);
          end
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          // Abort: revert the command; the set here overrides a same-cycle clear.
          pwr_d[grant_q] = stat_q[grant_q];
          err_d[grant_q] = 1'b1;
          if (GAP_CYC == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            gap_d   = GapW'(GAP_CYC - 1);
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pwr_q   <= RST_PWR;
      stat_q  <= RST_PWR;
      err_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pwr_q   <= pwr_d;
      stat_q  <= stat_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.pwr   = pwr_q;
  assign bus.stat  = stat_q;
  assign bus.err   = err_q;
  assign bus.grant = grant_q;
  assign bus.busy  = (state_q != StIdle);

endmodule
